// File: rtl/stage_1.sv
// Instruction fetch stage: PC register, small writable instruction memory,
// and the IF/ID pipeline register with the register-file read-enable decode.
module stage_1 #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Stall_IF,
    input  logic                          Flush_IF,
    input  logic                          Branch_Taken,
    input  logic [31:0]                   Branch_Target,
    input  logic                          Imem_We,
    input  logic [$clog2(IMEM_DEPTH)-1:0] Imem_Addr,
    input  logic [31:0]                   Imem_Wdata,
    output logic [31:0]                   PC_IF,
    output logic [31:0]                   PC_ID,
    output logic [31:0]                   IR,
    output logic [4:0]                    rs1_ID,
    output logic [4:0]                    rs2_ID,
    output logic [4:0]                    rd_ID,
    output logic [2:0]                    Func3_ID,
    output logic                          Read_Enable_1,
    output logic                          Read_Enable_2,
    output logic                          Valid_ID,
    output logic                          Misaligned_IF
);

    localparam int          ADDR_W = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [ADDR_W-1:0] fetch_index;
    logic [31:0]       fetch_word;
    logic [6:0]        opcode;

    // Upper PC bits are ignored so fetch addresses wrap around the memory.
    assign fetch_index = PC_IF[ADDR_W+1:2];
    assign fetch_word  = imem[fetch_index];
    assign opcode      = IR[6:0];

    // Instruction memory write port; left alone by Reset so a program can be
    // loaded while the pipeline is held in reset.
    always_ff @(posedge Clk) begin
        if (Imem_We) begin
            imem[Imem_Addr] <= Imem_Wdata;
        end
    end

    // Fetch PC: a redirect wins over a stall, otherwise advance by one word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC_IF         <= RESET_PC;
            Misaligned_IF <= 1'b0;
        end else begin
            Misaligned_IF <= Branch_Taken && (Branch_Target[1:0] != 2'b00);
            if (Branch_Taken) begin
                PC_IF <= {Branch_Target[31:2], 2'b00};
            end else if (!Stall_IF) begin
                PC_IF <= PC_IF + 32'd4;
            end
        end
    end

    // IF/ID register: a redirect or flush squashes the slot even when stalled.
    always_ff @(posedge Clk) begin
        if (Reset || Branch_Taken || Flush_IF) begin
            IR       <= NOP_IR;
            PC_ID    <= 32'd0;
            Valid_ID <= 1'b0;
        end else if (!Stall_IF) begin
            IR       <= fetch_word;
            PC_ID    <= PC_IF;
            Valid_ID <= 1'b1;
        end
    end

    // Field slices and register-file read enables decoded from the held IR.
    always_comb begin
        rs1_ID        = IR[19:15];
        rs2_ID        = IR[24:20];
        rd_ID         = IR[11:7];
        Func3_ID      = IR[14:12];
        Read_Enable_1 = 1'b0;
        Read_Enable_2 = 1'b0;
        if (Valid_ID) begin
            Read_Enable_1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
            Read_Enable_2 = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
        end
    end

endmodule
